// File: rtl/fir_pkg.sv
// Shared constants for the 8-tap odd-coefficient FIR datapath.
package fir_pkg;

  localparam int TAPS   = 8;
  localparam int P_W    = 12;
  localparam int ACC_W  = 14;
  localparam int FILL_W = 3;

  // Coefficient c_k = 2k+1; consumed by the multiplier bank and the bench model.
  localparam int unsigned COEF [TAPS] = '{1, 3, 5, 7, 9, 11, 13, 15};

  // Fill count at which the delay chain holds a full window of real samples.
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS - 1);

endpackage

// File: rtl/fir_tap_stage.sv
// One transposed-form stage: adds the local product to the downstream
// partial sum and registers the result.
module fir_tap_stage #(
  parameter int P_W   = 12,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [P_W-1:0]   prod,
  input  logic [ACC_W-1:0] carry,
  output logic [ACC_W-1:0] q
);

  // Partial-sum register: reset and clear flush it, enable advances it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every stage samples its neighbour's
    // pre-edge value; blocking here would ripple a sample through the chain.
    if (!rst_n || clear) begin
      q <= '0;
    end else if (en) begin
      q <= ACC_W'(prod) + carry;
    end
  end

endmodule

// File: rtl/fir_tap_combiner.sv
// Transposed-form delay/adder chain of the 8-tap FIR. Takes the per-tap
// products of one sample per accept and produces y[n] = sum c_k * x[n-k].
module fir_tap_combiner #(
  parameter int TAPS  = fir_pkg::TAPS,
  parameter int P_W   = fir_pkg::P_W,
  parameter int ACC_W = fir_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_clear,
  input  logic [P_W-1:0]   in_data1,
  input  logic [P_W-1:0]   in_data2,
  input  logic [P_W-1:0]   in_data3,
  input  logic [P_W-1:0]   in_data4,
  input  logic [P_W-1:0]   in_data5,
  input  logic [P_W-1:0]   in_data6,
  input  logic [P_W-1:0]   in_data7,
  input  logic [P_W-1:0]   in_data8,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid
);

  import fir_pkg::*;

  // prod[k] is c_k * x for the current sample.
  logic [P_W-1:0]   prod [TAPS];
  // r[k] is chain register r_k; r[TAPS] is the zero feeding the last stage.
  logic [ACC_W-1:0] r    [1:TAPS];
  logic [FILL_W-1:0] fill;
  logic              accept;

  assign prod[0] = in_data1;
  assign prod[1] = in_data2;
  assign prod[2] = in_data3;
  assign prod[3] = in_data4;
  assign prod[4] = in_data5;
  assign prod[5] = in_data6;
  assign prod[6] = in_data7;
  assign prod[7] = in_data8;

  assign r[TAPS] = '0;

  // Clear has priority inside each stage, so plain in_valid is a safe enable.
  assign accept = in_valid && !in_clear;

  // Stage k: r_k <= product k + r_(k+1); one adder per register on every path.
  for (genvar k = 1; k < TAPS; k++) begin : g_stage
    fir_tap_stage #(
      .P_W  (P_W),
      .ACC_W(ACC_W)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(in_clear),
      .en   (in_valid),
      .prod (prod[k]),
      .carry(r[k+1]),
      .q    (r[k])
    );
  end

  // Output register, priming counter and output strobe.
  always_ff @(posedge clk) begin
    if (!rst_n || in_clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      fill      <= '0;
    end else if (accept) begin
      out_data  <= ACC_W'(prod[0]) + r[1];
      out_valid <= (fill == FILL_MAX);
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
